mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter: DATA_W, 32, address/data width.
REQ-002 SHALL have parameter: MASK_W, DATA_W/8, byte-lane write mask width.
REQ-003 SHALL have port: clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: ifu_reqValid in 1, ifu_addr in DATA_W; ifu_respValid out 1, ifu_rdata out DATA_W (instruction fetch master, read-only).
REQ-006 SHALL have ports: lsu_reqValid in 1, lsu_wen in 1, lsu_addr in DATA_W, lsu_wdata in DATA_W, lsu_wbmask in MASK_W; lsu_respValid out 1, lsu_rdata out DATA_W (load/store master).
REQ-007 SHALL have ports: mem_reqValid out 1, mem_wen out 1, mem_addr out DATA_W, mem_wdata out DATA_W, mem_wbmask out MASK_W; mem_respValid in 1, mem_rdata in DATA_W (single shared memory port).
REQ-008 SHALL have ports: busy out 1 (state != IDLE); err out 1 (sticky spurious-response flag).

Function
REQ-009 SHALL implement FSM states IDLE, WAIT_IFU, WAIT_LSU, RESP; one outstanding memory transaction at most.
REQ-010 Masters hold reqValid and payload stable until their respValid, then deassert reqValid the following cycle.
REQ-011 In IDLE with exactly one reqValid high, SHALL grant that master: IDLE -> WAIT_IFU or WAIT_LSU.
REQ-012 With both high in IDLE, SHALL grant round-robin: the master not granted last wins; after reset LSU wins first.
REQ-013 On grant, SHALL register the master's payload into mem_addr/mem_wen/mem_wdata/mem_wbmask; IFU grant forces mem_wen=0, mem_wbmask=0, mem_wdata=0.
REQ-014 mem_reqValid SHALL be a registered one-cycle pulse in the first cycle of WAIT_*; payload outputs held stable through WAIT_*.
REQ-015 mem_respValid is accepted in any WAIT_* cycle, including the same cycle as mem_reqValid (zero-latency memory).
REQ-016 On accepted mem_respValid, SHALL latch mem_rdata into the granted master's rdata register and go to RESP.
REQ-017 In RESP, granted master's respValid SHALL be 1 for exactly one cycle; the other master's respValid stays 0; next state IDLE.
REQ-018 No grant SHALL occur in RESP; a pending request from either master is granted in the following IDLE cycle.
REQ-019 Latency: request seen in IDLE at cycle N -> mem_reqValid at N+1 -> mem_respValid at M>=N+1 -> master respValid at M+1; minimum 2 cycles request-to-response.
REQ-020 ifu_rdata/lsu_rdata SHALL hold their last latched value until the next response to that master.
REQ-021 mem_respValid in IDLE or RESP SHALL be ignored for data and SHALL set err; err clears only on reset.
REQ-022 lsu_wen=1 store responses SHALL still pulse lsu_respValid; lsu_rdata takes mem_rdata regardless.
REQ-023 Round-robin pointer SHALL update only on grant.

Reset
REQ-024 Reset low SHALL immediately force: state IDLE, all *_respValid 0, mem_reqValid 0, mem_wen 0, mem_wbmask 0, mem_addr/mem_wdata 0, ifu_rdata/lsu_rdata 0, err 0, busy 0, round-robin pointer to LSU-first.
REQ-025 Reset mid-transaction SHALL drop the transaction; a late mem_respValid after reset release while IDLE sets err per REQ-021.

Structure
REQ-026 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, WAIT_IFU, WAIT_LSU, RESP) and master-id constants (MST_IFU, MST_LSU).
REQ-027 SHALL be a single module with no sub-modules; memory itself stays external.

Verification
REQ-028 IFU alone: ifu_addr=0x80000000, memory latency 0 -> mem_reqValid 1 cycle, mem_wen=0, ifu_respValid at cycle N+2, ifu_rdata=mem_rdata=0x00100093.
REQ-029 Both request same cycle after reset, latency 3 -> LSU granted first (respValid at N+5), IFU granted in following IDLE; lsu_respValid and ifu_respValid never high together.
REQ-030 LSU store addr=0x80000010, wdata=0xDEADBEEF, wbmask=0x3 -> mem_wen=1, mem_wbmask=0x3, payload stable all WAIT cycles, one lsu_respValid pulse.
REQ-031 Spurious mem_respValid in IDLE -> no respValid to either master, rdata unchanged, err=1 until reset.
REQ-032 Reset asserted during WAIT_LSU with latency 5 -> outputs zero immediately, busy=0; after release new IFU request completes normally.
REQ-033 Continuous back-to-back requests from both masters for 20 transactions -> strict alternation LSU/IFU, 10 grants each.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and master ids for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IFU = 2'd1,
        WAIT_LSU = 2'd2,
        RESP     = 2'd3
    } state_e;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    // On contention the master that was not granted last wins.
    function automatic logic rr_pick(input logic ifu_req, input logic lsu_req, input logic last_gnt);
        if (ifu_req && lsu_req) begin
            return (last_gnt == MST_LSU) ? MST_IFU : MST_LSU;
        end
        return lsu_req ? MST_LSU : MST_IFU;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - request/response bundle between the two masters, the arbiter and memory
interface mem_arb_if #(
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
);
    logic              ifu_reqValid;
    logic [DATA_W-1:0] ifu_addr;
    logic              ifu_respValid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_reqValid;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wbmask;
    logic              lsu_respValid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_reqValid;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wbmask;
    logic              mem_respValid;
    logic [DATA_W-1:0] mem_rdata;

    // Environment side: both requesting masters plus the external memory.
    modport master (
        output ifu_reqValid, ifu_addr,
        input  ifu_respValid, ifu_rdata,
        output lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_wbmask,
        input  lsu_respValid, lsu_rdata,
        input  mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wbmask,
        output mem_respValid, mem_rdata
    );

    modport slave (
        input  ifu_reqValid, ifu_addr,
        output ifu_respValid, ifu_rdata,
        input  lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_wbmask,
        output lsu_respValid, lsu_rdata,
        output mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wbmask,
        input  mem_respValid, mem_rdata
    );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-master round-robin arbiter onto a single memory port, one transaction in flight
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic     clock,
    input  logic     reset,
    mem_arb_if.slave bus,
    output logic     busy,
    output logic     err
);

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              mreq_q, mreq_d;
    logic              mwen_q, mwen_d;
    logic [DATA_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [MASK_W-1:0] mmask_q, mmask_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              err_q, err_d;
    logic              sel;

    // last_gnt_q doubles as the response target in RESP; reset value makes LSU win first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= MST_IFU;
            mreq_q      <= 1'b0;
            mwen_q      <= 1'b0;
            maddr_q     <= '0;
            mwdata_q    <= '0;
            mmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            mreq_q      <= mreq_d;
            mwen_q      <= mwen_d;
            maddr_q     <= maddr_d;
            mwdata_q    <= mwdata_d;
            mmask_q     <= mmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        mreq_d      = 1'b0;
        mwen_d      = mwen_q;
        maddr_d     = maddr_q;
        mwdata_d    = mwdata_q;
        mmask_d     = mmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        err_d       = err_q;
        sel         = rr_pick(bus.ifu_reqValid, bus.lsu_reqValid, last_gnt_q);

        case (state_q)
            IDLE: begin
                if (bus.ifu_reqValid || bus.lsu_reqValid) begin
                    last_gnt_d = sel;
                    mreq_d     = 1'b1;
                    if (sel == MST_LSU) begin
                        state_d  = WAIT_LSU;
                        maddr_d  = bus.lsu_addr;
                        mwen_d   = bus.lsu_wen;
                        mwdata_d = bus.lsu_wdata;
                        mmask_d  = bus.lsu_wbmask;
                    end else begin
                        state_d  = WAIT_IFU;
                        maddr_d  = bus.ifu_addr;
                        mwen_d   = 1'b0;
                        mwdata_d = '0;
                        mmask_d  = '0;
                    end
                end
            end
            WAIT_IFU: begin
                if (bus.mem_respValid) begin
                    ifu_rdata_d = bus.mem_rdata;
                    state_d     = RESP;
                end
            end
            WAIT_LSU: begin
                if (bus.mem_respValid) begin
                    lsu_rdata_d = bus.mem_rdata;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A response with nothing outstanding is a protocol error on the memory side.
        if (bus.mem_respValid && (state_q == IDLE || state_q == RESP)) begin
            err_d = 1'b1;
        end
    end

    assign bus.mem_reqValid  = mreq_q;
    assign bus.mem_wen       = mwen_q;
    assign bus.mem_addr      = maddr_q;
    assign bus.mem_wdata     = mwdata_q;
    assign bus.mem_wbmask    = mmask_q;
    assign bus.ifu_rdata     = ifu_rdata_q;
    assign bus.lsu_rdata     = lsu_rdata_q;
    assign bus.ifu_respValid = (state_q == RESP) && (last_gnt_q == MST_IFU);
    assign bus.lsu_respValid = (state_q == RESP) && (last_gnt_q == MST_LSU);
    assign busy              = (state_q != IDLE);
    assign err               = err_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
module tb_mem_arb;

    logic clock;
    logic reset;
    logic busy;
    logic err;

    mem_arb_if #(.DATA_W(32)) bus ();

    mem_arb #(.DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic        ifu_en, lsu_en, ifu_req, lsu_req;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
    logic        lsu_wen;
    logic [3:0]  lsu_wbmask;
    logic        spur;
    int          lat;
    int          mcnt = 0;
    int          mreq_cnt = 0;
    int          both_hi = 0;
    logic        log_en = 1'b0;
    bit          gnt_log[$];

    assign bus.ifu_reqValid = ifu_req;
    assign bus.ifu_addr     = ifu_addr;
    assign bus.lsu_reqValid = lsu_req;
    assign bus.lsu_wen      = lsu_wen;
    assign bus.lsu_addr     = lsu_addr;
    assign bus.lsu_wdata    = lsu_wdata;
    assign bus.lsu_wbmask   = lsu_wbmask;

    // Memory: fixed latency after the request pulse, data derived from the address.
    assign bus.mem_rdata     = bus.mem_addr ^ 32'h8010_0093;
    assign bus.mem_respValid = spur | ((lat == 0) ? bus.mem_reqValid : (mcnt == lat));

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.mem_respValid)     mcnt <= 0;
        else if (bus.mem_reqValid) mcnt <= 1;
        else if (mcnt != 0)        mcnt <= mcnt + 1;
    end

    // Masters hold the request until their response, then drop it for one cycle.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifu_req <= 1'b0;
            lsu_req <= 1'b0;
        end else begin
            ifu_req <= bus.ifu_respValid ? 1'b0 : ifu_en;
            lsu_req <= bus.lsu_respValid ? 1'b0 : lsu_en;
        end
    end

    always @(negedge clock) begin
        if (bus.mem_reqValid) mreq_cnt++;
        if (bus.ifu_respValid && bus.lsu_respValid) both_hi++;
        if (log_en && gnt_log.size() < 20) begin
            if (bus.lsu_respValid) gnt_log.push_back(1'b1);
            if (bus.ifu_respValid) gnt_log.push_back(1'b0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_resp(input bit lsu, input string tag, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (lsu ? bus.lsu_respValid : bus.ifu_respValid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    int c0, t, base, n_lsu, n_ifu, n_rep;

    initial begin
        clock = 1'b0; reset = 1'b0; spur = 1'b0; lat = 0;
        ifu_en = 1'b0; lsu_en = 1'b0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wen = 1'b0; lsu_wbmask = '0;

        tick(2);
        check("rst_busy", busy, 0);
        check("rst_mreq", bus.mem_reqValid, 0);
        check("rst_maddr", bus.mem_addr, 0);
        check("rst_err", err, 0);
        check("rst_ifu_rdata", bus.ifu_rdata, 0);
        check("rst_resp", {bus.ifu_respValid, bus.lsu_respValid}, 0);
        reset = 1'b1;
        tick(1);

        // IFU alone, zero-latency memory
        lat = 0; ifu_addr = 32'h8000_0000; base = mreq_cnt; ifu_en = 1'b1;
        tick(1);
        check("ifu0_idle_busy", busy, 0);
        tick(1);
        check("ifu0_mreq", bus.mem_reqValid, 1);
        check("ifu0_mwen", bus.mem_wen, 0);
        check("ifu0_maddr", bus.mem_addr, 32'h8000_0000);
        tick(1);
        check("ifu0_resp", bus.ifu_respValid, 1);
        check("ifu0_rdata", bus.ifu_rdata, 32'h0010_0093);
        check("ifu0_lsu_quiet", bus.lsu_respValid, 0);
        ifu_en = 1'b0;
        tick(1);
        check("ifu0_resp_one", bus.ifu_respValid, 0);
        check("ifu0_mreq_cnt", mreq_cnt - base, 1);

        // Simultaneous requests after reset, latency 3: LSU first
        apply_reset();
        lat = 3; ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_0040;
        c0 = cyc; ifu_en = 1'b1; lsu_en = 1'b1;
        wait_resp(1, "rr_lsu", t);
        check("rr_lsu_lat", t - c0, 6);
        check("rr_lsu_rdata", bus.lsu_rdata, 32'h0010_00D3);
        check("rr_ifu_quiet", bus.ifu_respValid, 0);
        lsu_en = 1'b0;
        wait_resp(0, "rr_ifu", t);
        check("rr_ifu_lat", t - c0, 12);
        check("rr_ifu_rdata", bus.ifu_rdata, 32'h0010_0193);
        ifu_en = 1'b0;
        tick(1);

        // LSU store, latency 2: payload stable through all WAIT cycles
        lat = 2; lsu_addr = 32'h8000_0010; lsu_wdata = 32'hDEAD_BEEF; lsu_wbmask = 4'h3; lsu_wen = 1'b1;
        base = mreq_cnt; lsu_en = 1'b1;
        tick(1);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check($sformatf("st_maddr_%0d", i), bus.mem_addr, 32'h8000_0010);
            check($sformatf("st_mwen_%0d", i), bus.mem_wen, 1);
            check($sformatf("st_mask_%0d", i), bus.mem_wbmask, 4'h3);
            check($sformatf("st_wdata_%0d", i), bus.mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("st_mreq_%0d", i), bus.mem_reqValid, (i == 1));
        end
        tick(1);
        check("st_resp", bus.lsu_respValid, 1);
        check("st_ifu_quiet", bus.ifu_respValid, 0);
        check("st_rdata", bus.lsu_rdata, 32'h0010_0083);
        lsu_en = 1'b0;
        tick(1);
        check("st_resp_one", bus.lsu_respValid, 0);
        check("st_mreq_cnt", mreq_cnt - base, 1);
        check("st_ifu_rdata_held", bus.ifu_rdata, 32'h0010_0193);

        // Spurious response while idle
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        check("spur_err", err, 1);
        check("spur_resp", {bus.ifu_respValid, bus.lsu_respValid}, 0);
        tick(3);
        check("spur_err_sticky", err, 1);
        check("spur_busy", busy, 0);
        check("spur_ifu_rdata", bus.ifu_rdata, 32'h0010_0193);
        check("spur_lsu_rdata", bus.lsu_rdata, 32'h0010_0083);

        // Reset during WAIT_LSU, then a late response and a fresh IFU fetch
        lat = 5; lsu_addr = 32'h8000_0020; lsu_wdata = 32'h1234_5678; lsu_wbmask = 4'hF; lsu_wen = 1'b1;
        lsu_en = 1'b1;
        tick(2);
        check("mid_mreq", bus.mem_reqValid, 1);
        tick(1);
        check("mid_busy", busy, 1);
        reset = 1'b0; lsu_en = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mreq", bus.mem_reqValid, 0);
        check("mid_rst_maddr", bus.mem_addr, 0);
        check("mid_rst_mwen", bus.mem_wen, 0);
        check("mid_rst_mask", bus.mem_wbmask, 0);
        check("mid_rst_wdata", bus.mem_wdata, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rdata", {bus.ifu_rdata, bus.lsu_rdata}, 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("late_err_before", err, 0);
        tick(2);
        check("late_err", err, 1);
        check("late_lsu_quiet", bus.lsu_respValid, 0);
        check("late_lsu_rdata", bus.lsu_rdata, 0);
        ifu_addr = 32'h8000_0004; c0 = cyc; ifu_en = 1'b1;
        wait_resp(0, "post_ifu", t);
        check("post_ifu_lat", t - c0, 8);
        check("post_ifu_rdata", bus.ifu_rdata, 32'h0010_0097);
        ifu_en = 1'b0;
        tick(2);

        // Back-to-back traffic from both masters
        lat = 1; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wbmask = '0;
        gnt_log.delete(); log_en = 1'b1; ifu_en = 1'b1; lsu_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (gnt_log.size() >= 20) break;
        end
        ifu_en = 1'b0; lsu_en = 1'b0; log_en = 1'b0;
        tick(10);
        check("b2b_count", gnt_log.size(), 20);
        n_lsu = 0; n_ifu = 0; n_rep = 0;
        foreach (gnt_log[i]) begin
            if (gnt_log[i]) n_lsu++;
            else n_ifu++;
            if (i > 0 && gnt_log[i] == gnt_log[i-1]) n_rep++;
        end
        check("b2b_first_lsu", (gnt_log.size() > 0) ? gnt_log[0] : 1'b0, 1);
        check("b2b_lsu_n", n_lsu, 10);
        check("b2b_ifu_n", n_ifu, 10);
        check("b2b_alternate", n_rep, 0);
        check("never_both_resp", both_hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
